neck_judge_ctrl: RTL and testbench
==================================

Name: neck_judge_ctrl

Overview:
Parametrised successor to the fixed-threshold necking detector in the short-circuit welding controller. It consumes the 1st/2nd/3rd-order derivative samples of the arc signal and drives the welder power-enable. Thresholds are runtime-programmable, and start/end detection needs N consecutive qualifying samples. It adds a max-off timeout, a post-neck re-arm holdoff, and status/event-count outputs.

Parameters:
DW, 13, signed width of derivative samples and thresholds
CNT_W, 4, width of debounce count config/counter
TO_W, 16, width of timeout/holdoff config and cycle timer
NC_W, 16, width of neck event counter

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
en_judge  in  1  sample-valid strobe; derivative inputs evaluated only when 1
first_order_data  in  DW signed  1st-order derivative sample
second_order_data  in  DW signed  2nd-order derivative sample
third_order_data  in  DW signed  3rd-order derivative sample
cfg_th_d1  in  DW signed  d1 threshold (default 30)
cfg_th_d2s  in  DW signed  d2 start threshold (default 30)
cfg_th_d2e  in  DW signed  d2 end threshold (default -20)
cfg_th_d3  in  DW signed  d3 band half-width (default 40)
cfg_debounce  in  CNT_W  consecutive qualifying samples required; 0 treated as 1
cfg_timeout  in  TO_W  max cycles in OFF; 0 disables timeout
cfg_holdoff  in  TO_W  cycles ignored after power restore
power_switch  out  1  welder power enable (1 = on)
neck_active  out  1  1 while in OFF state
timeout_flag  out  1  one-cycle pulse on timeout exit from OFF
neck_count  out  NC_W  number of neck-start events, saturating

Behaviour:
- Reset (rst_n=0 at posedge): state ARMED, power_switch=1, neck_active=0, timeout_flag=0, neck_count=0, debounce counter and timer cleared. All outputs are registered.
- Conditions use strict signed DW-bit compares:
  - band = (d3 > -cfg_th_d3) && (d3 < cfg_th_d3). cfg_th_d3 <= 0 gives an empty band, so nothing qualifies.
  - start_hit = d1 > cfg_th_d1 && d2 > cfg_th_d2s && band
  - end_hit = d1 > cfg_th_d1 && d2 < cfg_th_d2e && band
- Debounce:
  - en_judge=1 with hit: counter +1, saturating.
  - en_judge=1 without hit: counter cleared.
  - en_judge=0: counter held.
  - Qualification occurs on the edge where the count including the current sample reaches max(cfg_debounce,1). The counter clears on every state change.
- ARMED: power_switch=1. On qualification of start_hit: go to OFF, power_switch=0, neck_active=1, neck_count+1 (saturates at all-ones). Latency is 0 cycles beyond the register: the output changes on the edge that samples the qualifying strobe.
- OFF: the timer counts every clk from 0 on entry.
  - end_hit qualified: go to HOLDOFF, power_switch=1, neck_active=0.
  - Otherwise, if cfg_timeout != 0 and timer+1 == cfg_timeout: go to HOLDOFF, power_switch=1, timeout_flag=1 for exactly one cycle.
  - If end qualification and timeout occur on the same edge, end wins and timeout_flag stays 0.
  - start_hit is ignored in OFF. The timer saturates and never wraps.
- HOLDOFF: power_switch=1. Samples are ignored and the debounce counter is held at 0. Return to ARMED after max(cfg_holdoff,1) cycles, with the timer cleared on entry.
- cfg_* inputs are read live; a change takes effect on the next compare. Changing cfg_timeout below the current timer value does not cause an immediate exit; the timer saturates and the timeout never fires until the next OFF entry.
- rst_n low in any state returns to reset values on the next edge. A low pulse between edges has no effect.
- With cfg_debounce=1, cfg_timeout=0, cfg_holdoff=0 and default thresholds, start/end response matches the legacy detector plus one holdoff cycle.

Decomposition:
- Package neck_pkg: state enum (ARMED, OFF, HOLDOFF); default threshold constants TH_D1=30, TH_D2S=30, TH_D2E=-20, TH_D3=40.
- Sub-module neck_debounce (CNT_W): hit, en, clr, target → qualified. Instantiate once and mux start_hit/end_hit by state.

Test Plan:
1. Defaults, debounce=1; en_judge=1 with (35,35,0) → power_switch 0 on that edge, neck_active=1, neck_count=1.
2. debounce=3 in ARMED: sequence hit, hit, miss, hit, hit, hit (all strobed), with an en_judge=0 gap inside the last run → power drops only on the third consecutive hit; the gap neither clears nor advances the count.
3. In OFF, (35,-25,10) ×debounce → power_switch 1. With holdoff=5, start samples during the next 5 cycles are ignored; a start on cycle 6 re-triggers and neck_count=2.
4. timeout=100 with no end samples → power_switch 1 on the 100th cycle after the drop and timeout_flag high for 1 cycle. A repeat with end qualifying on that exact edge → timeout_flag stays 0.
5. Boundaries: d1=30, d3=40, d3=-40, cfg_th_d3=0, and qualifying data with en_judge=0 → no transition in any case. neck_count at all-ones stays saturated on a further neck.
6. rst_n=0 for one edge mid-OFF (timer=50) → power_switch=1, state ARMED, neck_count=0, and the next start needs the full debounce again.

Source files
------------

// File: rtl/neck_judge_ctrl_pkg.sv
// Shared types and default thresholds for the necking detector.
// Thresholds are in derivative-sample units; the defaults match the legacy fixed detector.
package neck_pkg;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    OFF     = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam int TH_D1  = 30;
  localparam int TH_D2S = 30;
  localparam int TH_D2E = -20;
  localparam int TH_D3  = 40;

endpackage

// File: rtl/neck_judge_ctrl_if.sv
// Sample, config and status bundle between the derivative front end and the necking detector.
// No backpressure: en_judge is a plain valid strobe with no ready.
interface neck_judge_ctrl_if #(
  parameter int DW    = 13,
  parameter int CNT_W = 4,
  parameter int TO_W  = 16,
  parameter int NC_W  = 16
);
  logic                    en_judge;
  logic signed [DW-1:0]    first_order_data;
  logic signed [DW-1:0]    second_order_data;
  logic signed [DW-1:0]    third_order_data;
  logic signed [DW-1:0]    cfg_th_d1;
  logic signed [DW-1:0]    cfg_th_d2s;
  logic signed [DW-1:0]    cfg_th_d2e;
  logic signed [DW-1:0]    cfg_th_d3;
  logic [CNT_W-1:0]        cfg_debounce;
  logic [TO_W-1:0]         cfg_timeout;
  logic [TO_W-1:0]         cfg_holdoff;
  logic                    power_switch;
  logic                    neck_active;
  logic                    timeout_flag;
  logic [NC_W-1:0]         neck_count;

  modport master (
    output en_judge, first_order_data, second_order_data, third_order_data,
    output cfg_th_d1, cfg_th_d2s, cfg_th_d2e, cfg_th_d3,
    output cfg_debounce, cfg_timeout, cfg_holdoff,
    input  power_switch, neck_active, timeout_flag, neck_count
  );

  modport slave (
    input  en_judge, first_order_data, second_order_data, third_order_data,
    input  cfg_th_d1, cfg_th_d2s, cfg_th_d2e, cfg_th_d3,
    input  cfg_debounce, cfg_timeout, cfg_holdoff,
    output power_switch, neck_active, timeout_flag, neck_count
  );
endinterface

// File: rtl/neck_judge_ctrl_debounce.sv
// Consecutive-hit counter; qualified is combinational so the caller can act on the same edge.
// Latency 0 (qualified includes the current sample); en=0 holds the count, no backpressure.
module neck_debounce #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hit,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] target,
  output logic             qualified
);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] tgt;

  always_comb begin
    cnt_inc   = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    tgt       = (target == '0) ? CNT_W'(1) : target;
    // >= rather than == so a live lowering of target still qualifies
    qualified = en && hit && (cnt_inc >= tgt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= hit ? cnt_inc : '0;
    end
  end
endmodule

// File: rtl/neck_judge_ctrl.sv
// Necking detector: drops welder power on a debounced neck start, restores on end/timeout, then holds off.
// Outputs registered, change on the edge sampling the qualifying strobe; no backpressure.
module neck_judge_ctrl
  import neck_pkg::*;
#(
  parameter int DW    = 13,
  parameter int CNT_W = 4,
  parameter int TO_W  = 16,
  parameter int NC_W  = 16
) (
  input logic              clk,
  input logic              rst_n,
  neck_judge_ctrl_if.slave bus
);
  state_t               state;
  logic [TO_W-1:0]      timer;
  logic [TO_W-1:0]      timer_inc;
  logic [TO_W:0]        timer_p1;
  logic [TO_W-1:0]      hold_tgt;
  logic signed [DW-1:0] neg_th3;
  logic                 band, start_hit, end_hit, hit;
  logic                 qualified, tmo_hit, hold_done, clr;
  logic                 power_q, active_q, tflag_q;
  logic [NC_W-1:0]      count_q;

  always_comb begin
    neg_th3   = -bus.cfg_th_d3;
    band      = (bus.third_order_data > neg_th3) && (bus.third_order_data < bus.cfg_th_d3);
    start_hit = (bus.first_order_data > bus.cfg_th_d1) &&
                (bus.second_order_data > bus.cfg_th_d2s) && band;
    end_hit   = (bus.first_order_data > bus.cfg_th_d1) &&
                (bus.second_order_data < bus.cfg_th_d2e) && band;
    hit       = (state == ARMED) ? start_hit : ((state == OFF) ? end_hit : 1'b0);
    // one bit wider so a saturated timer can never alias onto cfg_timeout
    timer_p1  = {1'b0, timer} + (TO_W + 1)'(1);
    timer_inc = (timer == '1) ? timer : timer + TO_W'(1);
    hold_tgt  = (bus.cfg_holdoff == '0) ? TO_W'(1) : bus.cfg_holdoff;
    tmo_hit   = (state == OFF) && (bus.cfg_timeout != '0) &&
                (timer_p1 == {1'b0, bus.cfg_timeout});
    hold_done = (state == HOLDOFF) && (timer_p1 >= {1'b0, hold_tgt});
    clr       = (state == HOLDOFF) || qualified || tmo_hit;
  end

  neck_debounce #(.CNT_W(CNT_W)) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .hit       (hit),
    .en        (bus.en_judge),
    .clr       (clr),
    .target    (bus.cfg_debounce),
    .qualified (qualified)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ARMED;
      timer    <= '0;
      power_q  <= 1'b1;
      active_q <= 1'b0;
      tflag_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      tflag_q <= 1'b0;
      case (state)
        ARMED: begin
          timer <= '0;
          if (qualified) begin
            state    <= OFF;
            power_q  <= 1'b0;
            active_q <= 1'b1;
            if (count_q != '1) count_q <= count_q + NC_W'(1);
          end
        end
        OFF: begin
          if (qualified) begin
            state    <= HOLDOFF;
            timer    <= '0;
            power_q  <= 1'b1;
            active_q <= 1'b0;
          end else if (tmo_hit) begin
            state    <= HOLDOFF;
            timer    <= '0;
            power_q  <= 1'b1;
            active_q <= 1'b0;
            tflag_q  <= 1'b1;
          end else begin
            timer <= timer_inc;
          end
        end
        HOLDOFF: begin
          if (hold_done) begin
            state <= ARMED;
            timer <= '0;
          end else begin
            timer <= timer_inc;
          end
        end
        default: begin
          state <= ARMED;
          timer <= '0;
        end
      endcase
    end
  end

  assign bus.power_switch = power_q;
  assign bus.neck_active  = active_q;
  assign bus.timeout_flag = tflag_q;
  assign bus.neck_count   = count_q;
endmodule

// File: tb/tb_neck_judge_ctrl.sv
// Directed bench for neck_judge_ctrl; neck counter narrowed to 3 bits so saturation is reachable.
module tb_neck_judge_ctrl;
  import neck_pkg::*;

  localparam int DW    = 13;
  localparam int CNT_W = 4;
  localparam int TO_W  = 16;
  localparam int NC_W  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  neck_judge_ctrl_if #(.DW(DW), .CNT_W(CNT_W), .TO_W(TO_W), .NC_W(NC_W)) bus ();

  neck_judge_ctrl #(.DW(DW), .CNT_W(CNT_W), .TO_W(TO_W), .NC_W(NC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input int d1, input int d2, input int d3, input logic en);
    bus.first_order_data  = DW'(d1);
    bus.second_order_data = DW'(d2);
    bus.third_order_data  = DW'(d3);
    bus.en_judge          = en;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) smp(0, 0, 0, 1'b0);
  endtask

  task automatic outs(input string tag, input logic pw, input logic act, input logic tf, input int cnt);
    chk({tag, ".power"}, 32'(bus.power_switch), 32'(pw));
    chk({tag, ".active"}, 32'(bus.neck_active), 32'(act));
    chk({tag, ".tflag"}, 32'(bus.timeout_flag), 32'(tf));
    chk({tag, ".count"}, 32'(bus.neck_count), 32'(cnt));
  endtask

  initial begin
    bus.en_judge          = 1'b0;
    bus.first_order_data  = '0;
    bus.second_order_data = '0;
    bus.third_order_data  = '0;
    bus.cfg_th_d1    = DW'(TH_D1);
    bus.cfg_th_d2s   = DW'(TH_D2S);
    bus.cfg_th_d2e   = DW'(TH_D2E);
    bus.cfg_th_d3    = DW'(TH_D3);
    bus.cfg_debounce = CNT_W'(1);
    bus.cfg_timeout  = '0;
    bus.cfg_holdoff  = '0;

    tick();
    tick();
    outs("reset", 1'b1, 1'b0, 1'b0, 0);
    rst_n = 1'b1;

    // single-sample start and end at defaults
    smp(35, 35, 0, 1'b1);
    outs("t1_start", 1'b0, 1'b1, 1'b0, 1);
    smp(35, -25, 10, 1'b1);
    outs("t1_end", 1'b1, 1'b0, 1'b0, 1);
    idle(1);

    // debounce of 3 with a miss and an en_judge gap
    bus.cfg_debounce = CNT_W'(3);
    smp(35, 35, 0, 1'b1);
    smp(35, 35, 0, 1'b1);
    smp(0, 0, 0, 1'b1);
    smp(35, 35, 0, 1'b1);
    chk("t2_after_miss", 32'(bus.power_switch), 32'd1);
    smp(35, 35, 0, 1'b1);
    smp(35, 35, 0, 1'b0);
    chk("t2_gap", 32'(bus.power_switch), 32'd1);
    smp(35, 35, 0, 1'b1);
    outs("t2_drop", 1'b0, 1'b1, 1'b0, 2);
    smp(35, 35, 0, 1'b1);
    smp(35, -25, 10, 1'b1);
    smp(35, -25, 10, 1'b1);
    chk("t2_end_two", 32'(bus.power_switch), 32'd0);
    smp(35, -25, 10, 1'b1);
    chk("t2_end_three", 32'(bus.power_switch), 32'd1);
    idle(1);

    // holdoff of 5 ignores starts, the sixth cycle re-triggers
    bus.cfg_debounce = CNT_W'(1);
    bus.cfg_holdoff  = TO_W'(5);
    smp(35, 35, 0, 1'b1);
    chk("t3_drop_cnt", 32'(bus.neck_count), 32'd3);
    smp(35, -25, 10, 1'b1);
    chk("t3_restore", 32'(bus.power_switch), 32'd1);
    for (int i = 0; i < 5; i++) smp(35, 35, 0, 1'b1);
    outs("t3_holdoff", 1'b1, 1'b0, 1'b0, 3);
    smp(35, 35, 0, 1'b1);
    outs("t3_retrig", 1'b0, 1'b1, 1'b0, 4);
    bus.cfg_holdoff = '0;
    smp(35, -25, 10, 1'b1);
    idle(1);

    // timeout of 100, then end and timeout on the same edge
    bus.cfg_timeout = TO_W'(100);
    smp(35, 35, 0, 1'b1);
    idle(99);
    outs("t4_pre_tmo", 1'b0, 1'b1, 1'b0, 5);
    idle(1);
    outs("t4_tmo", 1'b1, 1'b0, 1'b1, 5);
    idle(1);
    chk("t4_tflag_pulse", 32'(bus.timeout_flag), 32'd0);
    smp(35, 35, 0, 1'b1);
    chk("t4b_drop", 32'(bus.power_switch), 32'd0);
    idle(99);
    smp(35, -25, 10, 1'b1);
    outs("t4b_end_wins", 1'b1, 1'b0, 1'b0, 6);
    idle(1);
    bus.cfg_timeout = '0;

    // threshold boundaries: none of these may trigger
    smp(30, 35, 0, 1'b1);
    smp(35, 30, 0, 1'b1);
    smp(35, 35, 40, 1'b1);
    smp(35, 35, -40, 1'b1);
    bus.cfg_th_d3 = '0;
    smp(35, 35, 0, 1'b1);
    bus.cfg_th_d3 = DW'(TH_D3);
    smp(35, 35, 0, 1'b0);
    outs("t5_boundaries", 1'b1, 1'b0, 1'b0, 6);
    smp(35, 35, 39, 1'b1);
    outs("t5_band_edge", 1'b0, 1'b1, 1'b0, 7);
    smp(35, -20, 0, 1'b1);
    chk("t5_d2e_edge", 32'(bus.power_switch), 32'd0);
    smp(35, -21, -39, 1'b1);
    chk("t5_end", 32'(bus.power_switch), 32'd1);
    idle(1);
    smp(35, 35, 0, 1'b1);
    outs("t5_saturate", 1'b0, 1'b1, 1'b0, 7);
    smp(35, -25, 10, 1'b1);
    idle(1);

    // reset mid-OFF with a partly filled debounce counter
    bus.cfg_debounce = CNT_W'(3);
    smp(35, 35, 0, 1'b1);
    smp(35, 35, 0, 1'b1);
    smp(35, 35, 0, 1'b1);
    chk("t6_drop", 32'(bus.power_switch), 32'd0);
    idle(48);
    smp(35, -25, 10, 1'b1);
    smp(35, -25, 10, 1'b1);
    chk("t6_off_still", 32'(bus.power_switch), 32'd0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    outs("t6_reset", 1'b1, 1'b0, 1'b0, 0);
    smp(35, 35, 0, 1'b1);
    chk("t6_first", 32'(bus.power_switch), 32'd1);
    smp(35, 35, 0, 1'b1);
    chk("t6_second", 32'(bus.power_switch), 32'd1);
    smp(35, 35, 0, 1'b1);
    outs("t6_third", 1'b0, 1'b1, 1'b0, 1);

    // reset glitch between edges is not sampled
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    idle(1);
    outs("t7_glitch", 1'b0, 1'b1, 1'b0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
